// File: rtl/ram_burst_ctrl_if.sv
// Host-side bus of the RAM burst controller: command channel, write-beat
// channel, read-beat channel and status. The controller uses the slave
// modport; the command source uses the master modport.
interface ram_burst_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  // command channel
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  // write-beat channel
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  // read-beat channel
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  // status
  logic          busy;
  logic          done;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done
  );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a single-port AWxDW RAM (ADDR/DIN/DOUT/RI).
// Accepts burst commands on a valid/ready channel, streams write beats in and
// read beats out, and drives every RAM-side signal from a register so the RAM
// sees a glitch-free, single-cycle write strobe per accepted beat.
module ram_burst_ctrl #(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int READ_LAT = 2   // ram_addr update edge -> ram_dout sample edge, 1..4
) (
  input  logic          CLK,
  input  logic          RESETn,
  ram_burst_ctrl_if.slave host,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_ri,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_WAIT,
    RD_HOLD,
    DONE
  } state_t;

  localparam logic [2:0] WAIT_INIT = 3'(READ_LAT - 1);

  state_t        state_q;
  logic [AW-1:0] cur_addr_q;
  logic [AW-1:0] beats_q;
  logic [2:0]    wait_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_din_q;
  logic          ram_ri_q;
  logic          rd_valid_q;
  logic [DW-1:0] rd_data_q;
  logic          done_q;

  logic [AW-1:0] cur_addr_d;
  logic [AW-1:0] beats_d;
  logic          last_beat;
  logic          wr_fire;
  logic          rd_fire;

  // Next address (wraps modulo 2^AW), remaining-beat decrement and handshakes.
  always_comb begin
    cur_addr_d = cur_addr_q + AW'(1);
    beats_d    = beats_q - AW'(1);
    last_beat  = (beats_q == '0);
    wr_fire    = (state_q == WRITE) && host.wr_valid;
    rd_fire    = (state_q == RD_HOLD) && host.rd_ready;
  end

  // Burst FSM; all RAM-side and handshake outputs are registered here.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      beats_q    <= '0;
      wait_q     <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_ri_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      // Strobe and done are pulses: low unless re-armed below this cycle.
      ram_ri_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (host.cmd_valid) begin
            cur_addr_q <= host.cmd_addr;
            beats_q    <= host.cmd_len;
            state_q    <= host.cmd_write ? WRITE : RD_ISSUE;
          end
        end
        WRITE: begin
          if (wr_fire) begin
            ram_addr_q <= cur_addr_q;
            ram_din_q  <= host.wr_data;
            ram_ri_q   <= 1'b1;
            cur_addr_q <= cur_addr_d;
            if (last_beat) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              beats_q <= beats_d;
            end
          end
        end
        RD_ISSUE: begin
          ram_addr_q <= cur_addr_q;
          wait_q     <= WAIT_INIT;
          state_q    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (wait_q == '0) begin
            rd_data_q  <= ram_dout;
            rd_valid_q <= 1'b1;
            state_q    <= RD_HOLD;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
        RD_HOLD: begin
          if (rd_fire) begin
            rd_valid_q <= 1'b0;
            if (last_beat) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              cur_addr_q <= cur_addr_d;
              beats_q    <= beats_d;
              state_q    <= RD_ISSUE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign host.cmd_ready = (state_q == IDLE);
  assign host.wr_ready  = (state_q == WRITE);
  assign host.busy      = (state_q != IDLE);
  assign host.rd_valid  = rd_valid_q;
  assign host.rd_data   = rd_data_q;
  assign host.done      = done_q;

  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_ri   = ram_ri_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: three controllers (READ_LAT 2, 1, 4) share the
// same host stimulus, each with its own behavioural RAM. Lane 0 (READ_LAT 2)
// is scoreboarded for every test; lanes 1 and 2 are checked in the final
// latency sweep after a common reset brings all lanes back into step.
module tb_ram_burst_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [AW-1:0] cmd_len   = '0;
  logic          wr_valid  = 1'b0;
  logic [DW-1:0] wr_data   = '0;
  logic          rd_ready  = 1'b1;

  logic          crdy [3];
  logic          wrdy [3];
  logic          rdv  [3];
  logic          bsy  [3];
  logic          dn   [3];
  logic          ri   [3];
  logic [DW-1:0] rdd  [3];
  logic [DW-1:0] din  [3];
  logic [AW-1:0] raddr[3];

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;
  bit rr_rand  = 1'b0;
  int lat_tab [3] = '{2, 1, 4};

  logic [DW-1:0] model [16];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wexp_t;

  wexp_t         wq[$];
  logic [DW-1:0] rq[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

    ram_burst_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_ri;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] rd0, dly1, dly2, dly3;
    logic [DW-1:0] mem [16];

    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_write = cmd_write;
    assign bus.cmd_addr  = cmd_addr;
    assign bus.cmd_len   = cmd_len;
    assign bus.wr_valid  = wr_valid;
    assign bus.wr_data   = wr_data;
    assign bus.rd_ready  = rd_ready;

    ram_burst_ctrl #(.AW(AW), .DW(DW), .READ_LAT(LAT)) u_dut (
      .CLK     (clk),
      .RESETn  (rst_n),
      .host    (bus),
      .ram_addr(ram_addr),
      .ram_din (ram_din),
      .ram_ri  (ram_ri),
      .ram_dout(ram_dout)
    );

    initial for (int i = 0; i < 16; i++) mem[i] = '0;

    // RAM write port: stores on the edge after the controller raises RI.
    always @(posedge clk) if (ram_ri) mem[ram_addr] <= ram_din;

    // RAM read path: combinational array read followed by a delay line.
    assign rd0 = mem[ram_addr];
    always @(posedge clk) begin
      dly1 <= rd0;
      dly2 <= dly1;
      dly3 <= dly2;
    end
    assign ram_dout = (LAT == 1) ? rd0 : (LAT == 2) ? dly1 : (LAT == 3) ? dly2 : dly3;

    assign crdy[g]  = bus.cmd_ready;
    assign wrdy[g]  = bus.wr_ready;
    assign rdv[g]   = bus.rd_valid;
    assign rdd[g]   = bus.rd_data;
    assign bsy[g]   = bus.busy;
    assign dn[g]    = bus.done;
    assign ri[g]    = ram_ri;
    assign din[g]   = ram_din;
    assign raddr[g] = ram_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Read-ready driver: held high, or randomised every cycle for backpressure.
  always @(posedge clk) begin
    #1;
    rd_ready = rr_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Lane 0 monitor: write-strobe scoreboard, read-beat scoreboard, hold stability.
  wexp_t         mon_e;
  logic [DW-1:0] mon_r;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_d    = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ri[0]) begin
        if (wq.size() > 0) begin
          mon_e = wq.pop_front();
          check("wr_addr", 32'(raddr[0]), 32'(mon_e.a));
          check("wr_data", 32'(din[0]), 32'(mon_e.d));
        end else begin
          check("spurious_ri", 32'(ri[0]), 32'd0);
        end
      end
      if (hold_pend) begin
        check("hold_valid", 32'(rdv[0]), 32'd1);
        check("hold_data", 32'(rdd[0]), 32'(hold_d));
      end
      if (rdv[0] && rd_ready) begin
        if (rq.size() > 0) begin
          mon_r = rq.pop_front();
          check("rd_data", 32'(rdd[0]), 32'(mon_r));
        end else begin
          check("extra_rd_beat", 32'(rdv[0]), 32'd0);
        end
      end
      hold_pend = rdv[0] && !rd_ready;
      hold_d    = rdd[0];
      if (dn[0]) done_cnt++;
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic issue_cmd(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] len);
    bit ok = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = len;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (crdy[0]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_len   = AW'($urandom);
    check("cmd_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (dn[0]) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(ok), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(dn[0]), 32'd0);
    check("idle_after_done", 32'(crdy[0]), 32'd1);
  endtask

  task automatic wr_burst(input logic [AW-1:0] a, input logic [AW-1:0] len,
                          input logic [DW-1:0] d0, input int gap, input bit rnd);
    logic [AW-1:0] ai;
    logic [DW-1:0] d;
    bit            ok;
    issue_cmd(1'b1, a, len);
    for (int i = 0; i <= int'(len); i++) begin
      ai = a + AW'(i);
      d  = rnd ? DW'($urandom) : d0 + DW'(i);
      wq.push_back('{a: ai, d: d});
      model[ai] = d;
      wr_valid  = 1'b1;
      wr_data   = d;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (wrdy[0]) begin
          ok = 1'b1;
          break;
        end
      end
      check("wr_accept", 32'(ok), 32'd1);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      wr_data  = DW'($urandom);
      if (i < int'(len)) repeat (gap) begin
        @(posedge clk); #1;
      end
    end
    wait_done(20);
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input logic [AW-1:0] len, input bit noise);
    int n  = 0;
    bit ok = 1'b0;
    for (int i = 0; i <= int'(len); i++) rq.push_back(model[a + AW'(i)]);
    issue_cmd(1'b0, a, len);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if (rdv[0]) begin
        ok = 1'b1;
        break;
      end
    end
    check("rd_first_seen", 32'(ok), 32'd1);
    check("rd_first_lat", 32'(n), 32'(lat_tab[0] + 2));
    if (noise) begin
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = AW'($urandom);
        wr_valid  = 1'b1;
        wr_data   = DW'($urandom);
        @(negedge clk);
        check("cmd_ready_busy", 32'(crdy[0]), 32'd0);
        check("wr_ready_in_read", 32'(wrdy[0]), 32'd0);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wr_valid  = 1'b0;
    end
    wait_done(2000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            saved_done;
    bit            seen [3];
    int            lat  [3];
    logic [DW-1:0] dat  [3];
    bit            idle;

    for (int i = 0; i < 16; i++) model[i] = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_addr", 32'(raddr[0]), 32'd0);
    check("rst_ram_din", 32'(din[0]), 32'd0);
    check("rst_ram_ri", 32'(ri[0]), 32'd0);
    check("rst_rd_valid", 32'(rdv[0]), 32'd0);
    check("rst_rd_data", 32'(rdd[0]), 32'd0);
    check("rst_done", 32'(dn[0]), 32'd0);
    check("rst_busy", 32'(bsy[0]), 32'd0);
    check("rst_wr_ready", 32'(wrdy[0]), 32'd0);
    check("rst_cmd_ready", 32'(crdy[0]), 32'd1);
    rst_n = 1'b1;

    // single write then read
    wr_burst(4'd3, 4'd0, 8'hA5, 0, 1'b0);
    rd_burst(4'd3, 4'd0, 1'b0);

    // wrapping burst 14,15,0,1
    wr_burst(4'd14, 4'd3, 8'h10, 0, 1'b0);
    rd_burst(4'd14, 4'd3, 1'b0);

    // full 16-beat write, then read back under random backpressure
    wr_burst(4'd0, 4'd15, 8'h00, 0, 1'b1);
    rr_rand = 1'b1;
    rd_burst(4'd0, 4'd15, 1'b0);
    rr_rand = 1'b0;

    // gapped write beats, then a read with command/write noise while busy
    wr_burst(4'd5, 4'd3, 8'h60, 2, 1'b0);
    rd_burst(4'd5, 4'd3, 1'b1);

    // reset during the 3rd beat of an 8-beat write
    saved_done = done_cnt;
    issue_cmd(1'b1, 4'd0, 4'd7);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h50 + DW'(i);
      if (i < 2) begin
        wq.push_back('{a: AW'(i), d: 8'h50 + DW'(i)});
        model[i] = 8'h50 + DW'(i);
      end
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (wrdy[0]) break;
      end
      @(posedge clk); #1;
    end
    check("ri_before_reset", 32'(ri[0]), 32'd1);
    #1;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    #1;
    check("abort_ri", 32'(ri[0]), 32'd0);
    check("abort_busy", 32'(bsy[0]), 32'd0);
    check("abort_rd_valid", 32'(rdv[0]), 32'd0);
    check("abort_done", 32'(dn[0]), 32'd0);
    check("abort_ram_addr", 32'(raddr[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("abort_no_done", 32'(done_cnt), 32'(saved_done));
    rd_burst(4'd1, 4'd0, 1'b0);

    // READ_LAT sweep across all three lanes
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_burst(4'd9, 4'd0, 8'h3C, 0, 1'b0);
    rq.push_back(model[9]);
    for (int g = 0; g < 3; g++) begin
      seen[g] = 1'b0;
      lat[g]  = 0;
      dat[g]  = '0;
    end
    issue_cmd(1'b0, 4'd9, 4'd0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (!seen[g] && rdv[g]) begin
          seen[g] = 1'b1;
          lat[g]  = k;
          dat[g]  = rdd[g];
        end
      end
    end
    for (int g = 0; g < 3; g++) begin
      check($sformatf("sweep_lat_L%0d", lat_tab[g]), 32'(lat[g]), 32'(lat_tab[g] + 2));
      check($sformatf("sweep_data_L%0d", lat_tab[g]), 32'(dat[g]), 32'(model[9]));
    end
    idle = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!bsy[0] && !bsy[1] && !bsy[2]) begin
        idle = 1'b1;
        break;
      end
    end
    check("sweep_idle", 32'(idle), 32'd1);

    check("wq_empty", 32'(wq.size()), 32'd0);
    check("rq_empty", 32'(rq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
